// File: rtl/text_writer.sv
// Character-stream front end for the 160x64 tile buffer: accepts ASCII codes,
// tracks a cursor, issues single-tile writes and sweeps clears for lines/screen.
module text_writer #(
  parameter int              H_TILES        = 160,
  parameter int              V_TILES        = 64,
  parameter int              ADDR_COL_WIDTH = 8,
  parameter int              ADDR_ROW_WIDTH = 6,
  parameter int              DATA_WIDTH     = 7,
  parameter logic [DATA_WIDTH-1:0] CLR_CHAR = 7'd0
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [DATA_WIDTH-1:0]     char_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic                      wr_en_o,
  output logic [ADDR_COL_WIDTH-1:0] col_w_o,
  output logic [ADDR_ROW_WIDTH-1:0] row_w_o,
  output logic [DATA_WIDTH-1:0]     din_o,
  output logic [ADDR_COL_WIDTH-1:0] cur_col_o,
  output logic [ADDR_ROW_WIDTH-1:0] cur_row_o
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_CLR_LINE   = 2'd1;
  localparam logic [1:0] ST_CLR_SCREEN = 2'd2;

  localparam logic [ADDR_COL_WIDTH-1:0] LAST_COL = ADDR_COL_WIDTH'(H_TILES - 1);
  localparam logic [ADDR_ROW_WIDTH-1:0] LAST_ROW = ADDR_ROW_WIDTH'(V_TILES - 1);

  localparam logic [DATA_WIDTH-1:0] CH_BS    = DATA_WIDTH'(8);
  localparam logic [DATA_WIDTH-1:0] CH_LF    = DATA_WIDTH'(10);
  localparam logic [DATA_WIDTH-1:0] CH_FF    = DATA_WIDTH'(12);
  localparam logic [DATA_WIDTH-1:0] CH_CR    = DATA_WIDTH'(13);
  localparam logic [DATA_WIDTH-1:0] CH_SPACE = DATA_WIDTH'(32);
  localparam logic [DATA_WIDTH-1:0] CH_TILDE = DATA_WIDTH'(126);

  logic [1:0]                r_state;
  logic [ADDR_COL_WIDTH-1:0] r_cur_col;
  logic [ADDR_ROW_WIDTH-1:0] r_cur_row;
  logic [ADDR_COL_WIDTH-1:0] r_sw_col;
  logic [ADDR_ROW_WIDTH-1:0] r_sw_row;
  logic                      r_wr_en;
  logic [ADDR_COL_WIDTH-1:0] r_col_w;
  logic [ADDR_ROW_WIDTH-1:0] r_row_w;
  logic [DATA_WIDTH-1:0]     r_din;

  logic [ADDR_ROW_WIDTH-1:0] w_next_row;
  logic                      w_printable;

  assign ready_o     = (r_state == ST_IDLE);
  assign w_next_row  = (r_cur_row == LAST_ROW) ? '0 : r_cur_row + ADDR_ROW_WIDTH'(1);
  assign w_printable = (char_i >= CH_SPACE) && (char_i <= CH_TILDE);

  assign wr_en_o   = r_wr_en;
  assign col_w_o   = r_col_w;
  assign row_w_o   = r_row_w;
  assign din_o     = r_din;
  assign cur_col_o = r_cur_col;
  assign cur_row_o = r_cur_row;

  // Cursor, sweep counters and registered write port; wr_en is a one-cycle strike.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= ST_IDLE;
      r_cur_col <= '0;
      r_cur_row <= '0;
      r_sw_col  <= '0;
      r_sw_row  <= '0;
      r_wr_en   <= 1'b0;
      r_col_w   <= '0;
      r_row_w   <= '0;
      r_din     <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (valid_i) begin
            if (w_printable) begin
              r_wr_en <= 1'b1;
              r_col_w <= r_cur_col;
              r_row_w <= r_cur_row;
              r_din   <= char_i;
              if (r_cur_col == LAST_COL) begin
                r_cur_col <= '0;
                r_cur_row <= w_next_row;
                r_sw_col  <= '0;
                r_sw_row  <= w_next_row;
                r_state   <= ST_CLR_LINE;
              end else begin
                r_cur_col <= r_cur_col + ADDR_COL_WIDTH'(1);
              end
            end else if (char_i == CH_CR) begin
              r_cur_col <= '0;
            end else if (char_i == CH_LF) begin
              r_cur_col <= '0;
              r_cur_row <= w_next_row;
              r_sw_col  <= '0;
              r_sw_row  <= w_next_row;
              r_state   <= ST_CLR_LINE;
            end else if (char_i == CH_BS) begin
              // Backspace at column 0 is swallowed without a write.
              if (r_cur_col != '0) begin
                r_cur_col <= r_cur_col - ADDR_COL_WIDTH'(1);
                r_wr_en   <= 1'b1;
                r_col_w   <= r_cur_col - ADDR_COL_WIDTH'(1);
                r_row_w   <= r_cur_row;
                r_din     <= CLR_CHAR;
              end else begin
                r_cur_col <= r_cur_col;
              end
            end else if (char_i == CH_FF) begin
              r_cur_col <= '0;
              r_cur_row <= '0;
              r_sw_col  <= '0;
              r_sw_row  <= '0;
              r_state   <= ST_CLR_SCREEN;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CLR_LINE: begin
          r_wr_en <= 1'b1;
          r_col_w <= r_sw_col;
          r_row_w <= r_sw_row;
          r_din   <= CLR_CHAR;
          if (r_sw_col == LAST_COL) begin
            r_state <= ST_IDLE;
          end else begin
            r_sw_col <= r_sw_col + ADDR_COL_WIDTH'(1);
          end
        end
        ST_CLR_SCREEN: begin
          r_wr_en <= 1'b1;
          r_col_w <= r_sw_col;
          r_row_w <= r_sw_row;
          r_din   <= CLR_CHAR;
          if (r_sw_col == LAST_COL) begin
            r_sw_col <= '0;
            if (r_sw_row == LAST_ROW) begin
              r_state <= ST_IDLE;
            end else begin
              r_sw_row <= r_sw_row + ADDR_ROW_WIDTH'(1);
            end
          end else begin
            r_sw_col <= r_sw_col + ADDR_COL_WIDTH'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
